// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter.
//   - parity mode encodings as driven on parity_mode
//   - transmitter FSM state encoding
//   - parity helpers used when a word is loaded into the shifter
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Widest supported data word; narrower words are zero-extended before
   // parity is computed, which leaves the XOR unchanged.
   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Mode 2'b11 is treated as no parity.
   function automatic logic parity_en(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [1:0]               mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO feeding the UART transmitter.
//   clk, rst     : clock, async active-high reset (flushes contents)
//   push, wdata  : write request and word; ignored while full
//   pop          : remove head; ignored while empty
//   rdata        : current head, valid whenever !empty
//   full, empty  : occupancy flags
//   level        : occupancy 0..DEPTH
module uart_tx_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q;
      if (do_push) mem_d[wr_ptr_q] = wdata;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART-style serial frame transmitter with input FIFO.
//   clk, rst            : clock, async active-high reset
//   baud_pulse          : one-clk strobe ending each bit period
//   s_valid/s_ready     : word handshake into the FIFO (s_ready = !full)
//   s_data              : word to send, LSB first
//   parity_mode, stop2  : frame format, latched when a word is popped
//   dout                : registered serial line, idle high
//   busy, idle, tx_done : status; tx_done pulses as the last stop bit ends
//   fill_level          : FIFO occupancy
//
// state     | meaning
// ST_IDLE   | line high, waiting for a baud_pulse with FIFO non-empty
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first, idx_q counts bits sent
// ST_PARITY | parity bit of the latched word
// ST_STOP   | 1 or 2 stop bits; may reload directly into ST_START
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter  int DATA_BITS  = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_pulse,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   output logic                 dout,
   output logic                 busy,
   output logic                 idle,
   output logic                 tx_done,
   output logic [CNT_W-1:0]     fill_level
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 fifo_full, fifo_empty, fifo_pop, load;
   logic [DATA_BITS-1:0] fifo_rdata;

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [1:0]           par_mode_q, par_mode_d;
   logic                 stop2_q, stop2_d;
   logic                 par_bit_q, par_bit_d;
   logic                 dout_q, dout_d;
   logic                 tx_done_q, tx_done_d;

   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid && !fifo_full),
      .pop   (fifo_pop),
      .wdata (s_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fill_level)
   );

   assign s_ready = !fifo_full;
   assign dout    = dout_q;
   assign tx_done = tx_done_q;
   assign busy    = (state_q != ST_IDLE);
   assign idle    = (state_q == ST_IDLE) && fifo_empty;

   // dout_d always carries the level of the bit period that begins on this
   // edge, so the line and the state move together. The shifter moves right
   // as bits go out, so shift_q[0] is always the next data bit; parity is
   // captured from the whole word at load time for that reason.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      stop_cnt_d = stop_cnt_q;
      par_mode_d = par_mode_q;
      stop2_d    = stop2_q;
      par_bit_d  = par_bit_q;
      dout_d     = dout_q;
      tx_done_d  = 1'b0;
      fifo_pop   = 1'b0;
      load       = 1'b0;
      if (baud_pulse) begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
               state_d = ST_DATA;
               idx_d   = '0;
               dout_d  = shift_q[0];
               shift_d = shift_q >> 1;
            end
            ST_DATA: begin
               if (idx_q == IDX_LAST) begin
                  if (parity_en(par_mode_q)) begin
                     state_d = ST_PARITY;
                     dout_d  = par_bit_q;
                  end else begin
                     state_d    = ST_STOP;
                     dout_d     = 1'b1;
                     stop_cnt_d = 1'b0;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  dout_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
            ST_PARITY: begin
               state_d    = ST_STOP;
               dout_d     = 1'b1;
               stop_cnt_d = 1'b0;
            end
            ST_STOP: begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  tx_done_d = 1'b1;
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     dout_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               dout_d  = 1'b1;
            end
         endcase
      end
      // Shared by the idle start and the back-to-back reload from ST_STOP.
      if (load) begin
         fifo_pop   = 1'b1;
         state_d    = ST_START;
         dout_d     = 1'b0;
         shift_d    = fifo_rdata;
         par_mode_d = parity_mode;
         stop2_d    = stop2;
         par_bit_d  = parity_bit(MAX_DATA_BITS'(fifo_rdata), parity_mode);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         idx_q      <= '0;
         stop_cnt_q <= 1'b0;
         par_mode_q <= PAR_NONE;
         stop2_q    <= 1'b0;
         par_bit_q  <= 1'b0;
         dout_q     <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         stop_cnt_q <= stop_cnt_d;
         par_mode_q <= par_mode_d;
         stop2_q    <= stop2_d;
         par_bit_q  <= par_bit_d;
         dout_q     <= dout_d;
         tx_done_q  <= tx_done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame (DATA_BITS=8, FIFO_DEPTH=4).
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_pulse;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       dout;
   logic       busy;
   logic       idle;
   logic       tx_done;
   logic [2:0] fill_level;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int pushed_cnt = 0;
   logic done_seen;
   logic exp_q [$];

   // exp holds the line level per bit period, left-aligned in send order.
   typedef struct packed {
      logic [7:0]  data;
      logic [1:0]  mode;
      logic        stop2;
      logic [3:0]  len;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs [6];

   uart_tx_frame #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .baud_pulse  (baud_pulse),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .dout        (dout),
      .busy        (busy),
      .idle        (idle),
      .tx_done     (tx_done),
      .fill_level  (fill_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (tx_done === 1'b1) done_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock; a pending word is dropped from s_valid once accepted.
   task automatic tick();
      logic acc;
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         s_valid = 1'b0;
         pushed_cnt++;
      end
   endtask

   task automatic baud();
      baud_pulse = 1'b1;
      tick();
      done_seen  = tx_done;
      baud_pulse = 1'b0;
      tick();
      tick();
   endtask

   task automatic push(input logic [7:0] d);
      s_data  = d;
      s_valid = 1'b1;
      tick();
   endtask

   // Reference frame builder used for the FIFO ordering stream.
   task automatic add_frame(input logic [7:0] d, input logic [1:0] m, input logic s2);
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
      if (m == 2'b01) exp_q.push_back(^d);
      if (m == 2'b10) exp_q.push_back(~(^d));
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endtask

   task automatic run_frame(input vec_t v);
      int d0;
      parity_mode = v.mode;
      stop2       = v.stop2;
      push(v.data);
      chk("push_fill", 32'(fill_level), 32'd1);
      chk("push_idle", 32'(idle), 32'd0);
      chk("push_busy", 32'(busy), 32'd0);
      d0 = done_cnt;
      for (int i = 0; i < int'(v.len); i++) begin
         baud();
         chk("frame_bit", 32'(dout), 32'(v.exp[11-i]));
         chk("frame_busy", 32'(busy), 32'd1);
      end
      chk("frame_no_early_done", 32'(done_cnt - d0), 32'd0);
      baud();
      chk("frame_done_pulse", 32'(done_seen), 32'd1);
      chk("frame_end_dout", 32'(dout), 32'd1);
      chk("frame_end_idle", 32'(idle), 32'd1);
      chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      logic [23:0] bb;
      logic [20:0] mc;
      logic [7:0]  w [6];
      int          d0;

      vecs[0] = '{data: 8'hA5, mode: 2'b01, stop2: 1'b0, len: 4'd11, exp: {11'b01010010101, 1'b0}};
      vecs[1] = '{data: 8'h07, mode: 2'b10, stop2: 1'b0, len: 4'd11, exp: {11'b01110000001, 1'b0}};
      vecs[2] = '{data: 8'h07, mode: 2'b01, stop2: 1'b0, len: 4'd11, exp: {11'b01110000011, 1'b0}};
      vecs[3] = '{data: 8'h07, mode: 2'b00, stop2: 1'b0, len: 4'd10, exp: {10'b0111000001, 2'b00}};
      vecs[4] = '{data: 8'h5A, mode: 2'b11, stop2: 1'b1, len: 4'd11, exp: {11'b00101101011, 1'b0}};
      vecs[5] = '{data: 8'hFF, mode: 2'b10, stop2: 1'b1, len: 4'd12, exp: 12'b011111111111};

      rst = 1'b1; baud_pulse = 1'b0; s_valid = 1'b0; s_data = '0;
      parity_mode = 2'b00; stop2 = 1'b0; done_seen = 1'b0;
      tick(); tick();
      chk("rst_dout", 32'(dout), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
      rst = 1'b0;
      tick();
      baud();
      chk("idle_pulse_dout", 32'(dout), 32'd1);
      chk("idle_pulse_busy", 32'(busy), 32'd0);

      for (int k = 0; k < 6; k++) run_frame(vecs[k]);

      // Back-to-back frames with two stop bits and even parity.
      parity_mode = 2'b01; stop2 = 1'b1;
      push(8'h3C);
      push(8'hC3);
      chk("b2b_fill", 32'(fill_level), 32'd2);
      bb = {12'b000111100011, 12'b011000011011};
      d0 = done_cnt;
      for (int i = 0; i < 24; i++) begin
         baud();
         chk("b2b_bit", 32'(dout), 32'(bb[23-i]));
         if (i == 12) chk("b2b_first_done", 32'(done_seen), 32'd1);
      end
      baud();
      chk("b2b_last_done", 32'(done_seen), 32'd1);
      chk("b2b_idle", 32'(idle), 32'd1);
      chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

      // Overfill the FIFO while a frame is in flight.
      parity_mode = 2'b00; stop2 = 1'b0;
      w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp_q.delete();
      for (int k = 0; k < 6; k++) add_frame(w[k], 2'b00, 1'b0);
      pushed_cnt = 0;
      d0 = done_cnt;
      push(w[0]);
      baud();
      chk("fifo_bit", 32'(dout), 32'(exp_q[0]));
      for (int k = 1; k < 5; k++) push(w[k]);
      chk("fifo_full_level", 32'(fill_level), 32'd4);
      chk("fifo_full_ready", 32'(s_ready), 32'd0);
      push(w[5]);
      chk("fifo_full_hold", 32'(fill_level), 32'd4);
      chk("fifo_full_pending", 32'(s_valid), 32'd1);
      for (int i = 1; i < 60; i++) begin
         baud();
         chk("fifo_bit", 32'(dout), 32'(exp_q[i]));
      end
      baud();
      chk("fifo_end_idle", 32'(idle), 32'd1);
      chk("fifo_done_count", 32'(done_cnt - d0), 32'd6);
      chk("fifo_pushed", 32'(pushed_cnt), 32'd6);

      // parity_mode changes mid-frame; the next frame picks it up.
      parity_mode = 2'b01; stop2 = 1'b0;
      push(8'hA5);
      mc = {11'b01010010101, 10'b0111000001};
      for (int i = 0; i < 21; i++) begin
         baud();
         chk("mode_bit", 32'(dout), 32'(mc[20-i]));
         if (i == 2) begin
            parity_mode = 2'b00;
            push(8'h07);
         end
      end
      baud();
      chk("mode_done", 32'(done_seen), 32'd1);
      chk("mode_idle", 32'(idle), 32'd1);

      // Reset during data bit 3 with another word queued.
      parity_mode = 2'b01;
      push(8'hA5);
      baud();
      push(8'h99);
      for (int i = 0; i < 4; i++) baud();
      chk("pre_rst_bit3", 32'(dout), 32'd0);
      chk("pre_rst_fill", 32'(fill_level), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_dout", 32'(dout), 32'd1);
      chk("mid_rst_fill", 32'(fill_level), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(s_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      run_frame(vecs[3]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
